stream_fanout_buf: RTL and testbench

//  Registered N-way broadcast ("lazy fork") of one valid/ready stream to CHANNELS

---
 rtl/stream_fanout_buf.sv | 106 ++++++++++
 tb/tb_stream_fanout_buf.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fanout_buf.sv
// stream_fanout_buf: registered N-way broadcast ("lazy fork") of one
// valid/ready stream to CHANNELS consumers. Each consumer has its own
// back-pressure. Each enabled consumer sees every beat exactly once, in order.
//
// One holding register stores the beat. A per-channel done flag records
// which channels have already taken it. The beat retires when every channel
// is disabled, done, or taking in this cycle. A new beat can load in the same
// cycle, so throughput is one beat per cycle when all enabled channels are
// ready. The path from input to out_valid is always registered.
//
// Optional feature, macro STREAM_FANOUT_STATS_EN:
//   Adds parameter CNT_W, input cnt_clr and output beat_cnt. These are
//   per-channel counters of delivered beats; they wrap around.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_data/valid/ready  producer stream
//   chan_en              per-channel enable, sampled every cycle
//   out_data/valid/ready consumer streams; channel i uses [i*DATA_W +: DATA_W]
//   busy                 holding register occupied
//   cnt_clr, beat_cnt    counter clear / counts (stats build only)
module stream_fanout_buf #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 2
`ifdef STREAM_FANOUT_STATS_EN
  , parameter int CNT_W  = 16
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS-1:0]          chan_en,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic [CHANNELS-1:0]          out_valid,
  input  logic [CHANNELS-1:0]          out_ready,
`ifdef STREAM_FANOUT_STATS_EN
  input  logic                         cnt_clr,
  output logic [CHANNELS*CNT_W-1:0]    beat_cnt,
`endif
  output logic                         busy
);

  logic [DATA_W-1:0]   buf_data_q, buf_data_d;
  logic                buf_valid_q, buf_valid_d;
  logic [CHANNELS-1:0] done_q, done_d;
  logic [CHANNELS-1:0] take;
  logic                retire, load;

  // Enable is not latched per beat. Dropping chan_en[i] removes channel i
  // from the retire condition. Raising it before done[i] is set exposes the
  // beat to channel i.
  assign out_valid = {CHANNELS{buf_valid_q}} & chan_en & ~done_q;
  assign take      = out_valid & out_ready;
  assign retire    = buf_valid_q & (&(~chan_en | done_q | take));
  assign in_ready  = ~rst & (~buf_valid_q | retire);
  assign load      = in_valid & in_ready;
  assign busy      = buf_valid_q;

  always_comb begin
    buf_data_d  = buf_data_q;
    buf_valid_d = buf_valid_q;
    if (load) begin
      buf_data_d  = in_data;
      buf_valid_d = 1'b1;
    end else if (retire) begin
      buf_valid_d = 1'b0;
    end
    done_d = retire ? '0 : (done_q | take);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_data_q  <= '0;
      buf_valid_q <= 1'b0;
      done_q      <= '0;
    end else begin
      buf_data_q  <= buf_data_d;
      buf_valid_q <= buf_valid_d;
      done_q      <= done_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_out
    assign out_data[i*DATA_W +: DATA_W] = buf_data_q;
  end

`ifdef STREAM_FANOUT_STATS_EN
  for (genvar i = 0; i < CHANNELS; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // A clear in the same cycle as a take wins; the take is not counted.
    always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr)      cnt_d = '0;
      else if (take[i]) cnt_d = cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end
    assign beat_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_stream_fanout_buf.sv
module tb_stream_fanout_buf;
  localparam int DW = 8;
  localparam int CH = 3;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [DW-1:0]     in_data;
  logic              in_valid, in_ready;
  logic [CH-1:0]     chan_en, out_valid, out_ready;
  logic [CH*DW-1:0]  out_data;
  logic              busy;

  logic [DW-1:0]     a_in_data, a_out_data;
  logic              a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic              a_en;

`ifdef STREAM_FANOUT_STATS_EN
  logic              cnt_clr;
  logic [CH*CW-1:0]  beat_cnt;
  logic [CW-1:0]     a_beat_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  stream_fanout_buf #(.DATA_W(DW), .CHANNELS(CH)
`ifdef STREAM_FANOUT_STATS_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .chan_en(chan_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef STREAM_FANOUT_STATS_EN
    .cnt_clr(cnt_clr), .beat_cnt(beat_cnt),
`endif
    .busy(busy)
  );

  stream_fanout_buf #(.DATA_W(DW), .CHANNELS(1)
`ifdef STREAM_FANOUT_STATS_EN
    , .CNT_W(CW)
`endif
  ) dut1 (
    .clk(clk), .rst(rst),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .chan_en(a_en),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
`ifdef STREAM_FANOUT_STATS_EN
    .cnt_clr(cnt_clr), .beat_cnt(a_beat_cnt),
`endif
    .busy(a_busy)
  );

  // Inputs change at posedge+1; checks run at posedge+2, well before the next edge.
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; chan_en = '1; out_ready = '0;
    a_in_valid = 1'b0; a_in_data = '0; a_en = 1'b1; a_out_ready = 1'b0;
`ifdef STREAM_FANOUT_STATS_EN
    cnt_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_hi: got %b expected 0", in_ready); end
    n_chk++; if (out_valid !== 3'b000) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 000", out_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    rst = 1'b0; #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready_after: got %b expected 1", in_ready); end
    n_chk++; if (out_data !== 24'h0) begin n_fail++; $display("FAIL rst_out_data: got %h expected 000000", out_data); end
`ifdef STREAM_FANOUT_STATS_EN
    n_chk++; if (beat_cnt !== '0) begin n_fail++; $display("FAIL rst_beat_cnt: got %h expected 0", beat_cnt); end
`endif
    tick;
  endtask

  task automatic test_streaming;
    logic [7:0] b;
    chan_en = 3'b111; out_ready = 3'b111;
    for (int k = 0; k < 18; k++) begin
      in_valid = (k < 16);
      in_data  = 8'(k + 1);
      #1;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready k=%0d: got %b expected 1", k, in_ready); end
      if (k >= 1 && k <= 16) begin
        b = 8'(k);
        n_chk++; if (out_valid !== 3'b111) begin n_fail++; $display("FAIL stream_valid k=%0d: got %b expected 111", k, out_valid); end
        n_chk++; if (out_data !== {b, b, b}) begin n_fail++; $display("FAIL stream_data k=%0d: got %h expected %h", k, out_data, {b, b, b}); end
      end else begin
        n_chk++; if (out_valid !== 3'b000) begin n_fail++; $display("FAIL stream_idle k=%0d: got %b expected 000", k, out_valid); end
      end
      tick;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_skew;
    chan_en = 3'b111; out_ready = 3'b000; in_valid = 1'b1; in_data = 8'hA5;
    tick;
    in_data = 8'h5A; out_ready = 3'b001; #1;
    n_chk++; if (out_valid !== 3'b111) begin n_fail++; $display("FAIL skew_valid0: got %b expected 111", out_valid); end
    n_chk++; if (out_data !== 24'hA5A5A5) begin n_fail++; $display("FAIL skew_data: got %h expected a5a5a5", out_data); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skew_ready0: got %b expected 0", in_ready); end
    tick;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_chk++; if (out_valid !== 3'b110) begin n_fail++; $display("FAIL skew_valid_c%0d: got %b expected 110", c, out_valid); end
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skew_ready_c%0d: got %b expected 0", c, in_ready); end
      tick;
    end
    out_ready = 3'b110; #1;
    n_chk++; if (out_valid !== 3'b110) begin n_fail++; $display("FAIL skew_valid_last: got %b expected 110", out_valid); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL skew_retire_ready: got %b expected 1", in_ready); end
    tick;
    in_valid = 1'b0; out_ready = 3'b111; #1;
    n_chk++; if (out_valid !== 3'b111) begin n_fail++; $display("FAIL skew_next_valid: got %b expected 111", out_valid); end
    n_chk++; if (out_data !== 24'h5A5A5A) begin n_fail++; $display("FAIL skew_next_data: got %h expected 5a5a5a", out_data); end
    tick;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL skew_drain_busy: got %b expected 0", busy); end
  endtask

  task automatic test_mask;
    chan_en = 3'b111; out_ready = 3'b000; in_valid = 1'b1; in_data = 8'h3C;
    tick;
    in_valid = 1'b0; #1;
    n_chk++; if (out_valid !== 3'b111) begin n_fail++; $display("FAIL mask_valid0: got %b expected 111", out_valid); end
    tick;
    chan_en = 3'b101; out_ready = 3'b010; #1;
    n_chk++; if (out_valid !== 3'b101) begin n_fail++; $display("FAIL mask_valid1: got %b expected 101", out_valid); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mask_ready1: got %b expected 0", in_ready); end
    tick;
    out_ready = 3'b111; #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mask_retire: got %b expected 1", in_ready); end
    tick;
    chan_en = 3'b111; #1;
    n_chk++; if (out_valid !== 3'b000) begin n_fail++; $display("FAIL mask_ch1_never: got %b expected 000", out_valid); end
    // chan_en==0 while full discards the beat in one cycle
    out_ready = 3'b000; in_valid = 1'b1; in_data = 8'h99;
    tick;
    in_valid = 1'b0; chan_en = 3'b000; #1;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL discard_busy: got %b expected 1", busy); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL discard_ready: got %b expected 1", in_ready); end
    tick;
    chan_en = 3'b111; #1;
    n_chk++; if (busy !== 1'b0 || out_valid !== 3'b000) begin n_fail++; $display("FAIL discard_gone: got busy=%b valid=%b expected 0/000", busy, out_valid); end
    // enabling a channel mid-beat exposes the beat to it
    chan_en = 3'b011; in_valid = 1'b1; in_data = 8'h11;
    tick;
    in_valid = 1'b0; #1;
    n_chk++; if (out_valid !== 3'b011) begin n_fail++; $display("FAIL late_en_pre: got %b expected 011", out_valid); end
    chan_en = 3'b111; #1;
    n_chk++; if (out_valid !== 3'b111) begin n_fail++; $display("FAIL late_en_post: got %b expected 111", out_valid); end
    out_ready = 3'b111;
    tick;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL late_en_drain: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_beat;
    chan_en = 3'b111; out_ready = 3'b000; in_valid = 1'b1; in_data = 8'h77;
    tick;
    in_valid = 1'b0; out_ready = 3'b010;
    tick;
    out_ready = 3'b000; #1;
    n_chk++; if (out_valid !== 3'b101) begin n_fail++; $display("FAIL rmid_done: got %b expected 101", out_valid); end
    rst = 1'b1; #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ready_in_rst: got %b expected 0", in_ready); end
    tick;
    rst = 1'b0; #1;
    n_chk++; if (out_valid !== 3'b000) begin n_fail++; $display("FAIL rmid_valid: got %b expected 000", out_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    n_chk++; if (out_data !== 24'h0) begin n_fail++; $display("FAIL rmid_data: got %h expected 000000", out_data); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b expected 1", in_ready); end
    out_ready = 3'b111;
    tick;
    n_chk++; if (out_valid !== 3'b000) begin n_fail++; $display("FAIL rmid_never: got %b expected 000", out_valid); end
  endtask

`ifdef STREAM_FANOUT_STATS_EN
  task automatic test_stats;
    cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    n_chk++; if (beat_cnt !== '0) begin n_fail++; $display("FAIL stats_clr: got %h expected 0", beat_cnt); end
    chan_en = 3'b100; out_ready = 3'b100;
    for (int k = 0; k < 17; k++) begin
      in_valid = 1'b1; in_data = 8'(k);
      tick;
    end
    in_valid = 1'b0;
    tick;
    n_chk++; if (beat_cnt[11:8] !== 4'd1) begin n_fail++; $display("FAIL stats_wrap: got %0d expected 1", beat_cnt[11:8]); end
    n_chk++; if (beat_cnt[3:0] !== 4'd0) begin n_fail++; $display("FAIL stats_ch0: got %0d expected 0", beat_cnt[3:0]); end
    chan_en = 3'b111; out_ready = 3'b000; in_valid = 1'b1; in_data = 8'hE1;
    tick;
    in_valid = 1'b0; out_ready = 3'b100; cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    n_chk++; if (beat_cnt[11:8] !== 4'd0) begin n_fail++; $display("FAIL stats_clr_take: got %0d expected 0", beat_cnt[11:8]); end
    out_ready = 3'b111;
    tick;
  endtask
`endif

  task automatic test_single_channel;
    a_en = 1'b1; a_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_in_valid = (k < 3); a_in_data = 8'(8'h20 + k); #1;
      n_chk++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL ch1_ready k=%0d: got %b expected 1", k, a_in_ready); end
      if (k >= 1) begin
        n_chk++; if (a_out_valid !== 1'b1 || a_out_data !== 8'(8'h1F + k)) begin n_fail++; $display("FAIL ch1_stream k=%0d: got %b/%h expected 1/%h", k, a_out_valid, a_out_data, 8'(8'h1F + k)); end
      end
      tick;
    end
    a_in_valid = 1'b1; a_in_data = 8'h42;
    tick;
    a_in_data = 8'h43; a_out_ready = 1'b0; #1;
    n_chk++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h42) begin n_fail++; $display("FAIL ch1_hold: got %b/%h expected 1/42", a_out_valid, a_out_data); end
    n_chk++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL ch1_stall_ready: got %b expected 0", a_in_ready); end
    tick;
    n_chk++; if (a_out_data !== 8'h42) begin n_fail++; $display("FAIL ch1_stable: got %h expected 42", a_out_data); end
    a_out_ready = 1'b1; #1;
    n_chk++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL ch1_release: got %b expected 1", a_in_ready); end
    tick;
    a_in_valid = 1'b0; #1;
    n_chk++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h43) begin n_fail++; $display("FAIL ch1_next: got %b/%h expected 1/43", a_out_valid, a_out_data); end
    tick;
  endtask

  initial begin
    test_reset;
    test_streaming;
    test_skew;
    test_mask;
`ifdef STREAM_FANOUT_STATS_EN
    test_stats;
`endif
    test_single_channel;
    test_reset_mid_beat;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
